// File: rtl/instr_info_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_info_pkg                                                             |
// | Decoded-instruction record types shared by the instruction-info queue.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package instr_info_pkg;

   localparam int INFO_XLEN = 32;

   typedef enum logic [3:0] {
      UNKNOWN = 4'd0,
      ADD, SUB, ADDI, LW, SW, BEQ, BNE, JAL, JALR, LUI, AUIPC, ECALL
   } instr_name_e;

   typedef enum logic [2:0] {
      XX = 3'd0,
      R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
   } instr_type_e;

   typedef struct packed {
      logic [5:0] rd;
      logic [5:0] rs1;
      logic [5:0] rs2;
      logic [5:0] rs3;
   } registers_t;

   typedef struct packed {
      logic is_branch;
      logic is_load;
      logic is_store;
      logic is_compressed;
      logic is_illegal;
   } flag_vector_t;

   typedef struct packed {
      logic [INFO_XLEN-1:0] address;
      logic [INFO_XLEN-1:0] immediate;
      instr_name_e          instr_name;
      registers_t           regs;
      instr_type_e          instr_type;
      flag_vector_t         flags;
   } instr_info_t;

   localparam int INFO_W = $bits(instr_info_t);

   localparam instr_info_t INSTR_INFO_CLEARED = '{
      address:    '0,
      immediate:  '0,
      instr_name: UNKNOWN,
      regs:       '0,
      instr_type: XX,
      flags:      '0
   };

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

   // Number of consecutive set bits starting at bit 0.
   function automatic logic [2:0] lead_ones4(input logic [3:0] v);
      logic [2:0] n;
      logic       run;
      n   = '0;
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run = run & v[i];
         if (run) begin
            n = n + 3'd1;
         end
      end
      return n;
   endfunction

endpackage : instr_info_pkg
`default_nettype wire

// File: rtl/instr_info_ptr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_info_ptr_ctrl                                                        |
// | Head/tail/occupancy bookkeeping and lane handshakes for instr_info_queue.  |
// | Optional same-cycle bypass when empty: INSTR_INFO_QUEUE_BYPASS_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_info_ptr_ctrl
   import instr_info_pkg::*;
#(
   parameter  int DEPTH = 8,
   parameter  int WAYS  = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic [WAYS-1:0] in_valid_i,
   input  logic [WAYS-1:0] out_ready_i,
   output logic            in_ready_o,
   output logic [WAYS-1:0] out_valid_o,
   output logic            bypass_o,
   output logic [WAYS-1:0] wr_en_o,
   output logic [2:0]      wr_skip_o,
   output logic [PW-1:0]   head_o,
   output logic [PW-1:0]   tail_o,
   output logic [CW-1:0]   count_o
);

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [WAYS-1:0] in_take;
   logic [WAYS-1:0] stored_valid;
   logic [WAYS-1:0] out_take;
   logic [2:0]      n_in, n_take, n_out, n_skip;

   always_comb begin
      in_ready_o   = (count_q <= CW'(DEPTH - WAYS));
      in_take      = in_ready_o ? in_valid_i : '0;
      n_in         = popcount4(4'(in_take));
      stored_valid = '0;
      for (int w = 0; w < WAYS; w++) begin
         stored_valid[w] = (count_q > CW'(w));
      end
`ifdef INSTR_INFO_QUEUE_BYPASS_EN
      bypass_o = (count_q == '0) && !flush_i;
`else
      bypass_o = 1'b0;
`endif
      out_valid_o = bypass_o ? in_take : stored_valid;
      out_take    = out_valid_o & out_ready_i;
      n_take      = lead_ones4(4'(out_take));
      // Bypassed lanes consumed this cycle never touch storage.
      n_skip      = bypass_o ? n_take : 3'd0;
      n_out       = bypass_o ? 3'd0 : n_take;
      wr_skip_o   = n_skip;
      wr_en_o     = '0;
      for (int w = 0; w < WAYS; w++) begin
         wr_en_o[w] = !flush_i && (3'(w) < n_in) && (3'(w) >= n_skip);
      end
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(n_out);
         tail_d  = tail_q + PW'(n_in - n_skip);
         count_d = count_q + CW'(n_in) - CW'(n_skip) - CW'(n_out);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = head_q;
   assign tail_o  = tail_q;
   assign count_o = count_q;

endmodule : instr_info_ptr_ctrl
`default_nettype wire

// File: rtl/instr_info_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_info_queue                                                           |
// | Multi-lane FIFO of decoded-instruction records between decode and rename.  |
// | Optional same-cycle bypass when empty: INSTR_INFO_QUEUE_BYPASS_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_info_queue
   import instr_info_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int DEPTH = 8,
   parameter  int WAYS  = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic [WAYS-1:0]        in_valid,
   input  logic [WAYS*INFO_W-1:0] in_info,
   output logic                   in_ready,
   output logic [WAYS-1:0]        out_valid,
   output logic [WAYS*INFO_W-1:0] out_info,
   input  logic [WAYS-1:0]        out_ready,
   output logic [CW-1:0]          count,
   output logic                   full,
   output logic                   empty
);

   instr_info_t     mem_q [DEPTH];
   instr_info_t     in_rec [WAYS];
   logic            bypass;
   logic [WAYS-1:0] wr_en;
   logic [2:0]      wr_skip;
   logic [PW-1:0]   head, tail;
   logic [WAYS-1:0] in_valid_inc, out_ready_inc;

   instr_info_ptr_ctrl #(
      .DEPTH (DEPTH),
      .WAYS  (WAYS)
   ) u_ptr_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .out_ready_i (out_ready),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .bypass_o    (bypass),
      .wr_en_o     (wr_en),
      .wr_skip_o   (wr_skip),
      .head_o      (head),
      .tail_o      (tail),
      .count_o     (count)
   );

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Storage is deliberately left unreset; validity comes from count alone.
   always_ff @(posedge clk) begin
      for (int w = 0; w < WAYS; w++) begin
         if (wr_en[w]) begin
            mem_q[tail + PW'(w) - PW'(wr_skip)] <= in_rec[w];
         end
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_lane
      instr_info_t   out_rec;
      logic [PW-1:0] rd_idx;

      assign in_rec[w] = in_info[w*INFO_W +: INFO_W];
      assign rd_idx    = head + PW'(w);

      always_comb begin
         out_rec = INSTR_INFO_CLEARED;
         if (out_valid[w]) begin
            out_rec = bypass ? in_rec[w] : mem_q[rd_idx];
         end
      end

      assign out_info[w*INFO_W +: INFO_W] = out_rec;
   end

   assign in_valid_inc  = in_valid + WAYS'(1);
   assign out_ready_inc = out_ready + WAYS'(1);

   a_xlen_match: assert property (@(posedge clk) XLEN == INFO_XLEN);
   a_in_valid_contig: assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid & in_valid_inc) == '0);
   a_out_ready_contig: assert property (@(posedge clk) disable iff (!rst_n)
      (out_ready & out_ready_inc) == '0);
   a_out_ready_on_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (out_ready & ~out_valid) == '0);

endmodule : instr_info_queue
`default_nettype wire

// File: tb/tb_instr_info_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_info_queue                                                        |
// | Directed self-checking bench with a queue-level reference model.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_info_queue;
   import instr_info_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 8;
   localparam int WAYS  = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b1;
   logic                   flush = 1'b0;
   logic [WAYS-1:0]        in_valid = '0;
   logic [WAYS*INFO_W-1:0] in_info = '0;
   logic                   in_ready;
   logic [WAYS-1:0]        out_valid;
   logic [WAYS*INFO_W-1:0] out_info;
   logic [WAYS-1:0]        out_ready = '0;
   logic [CW-1:0]          count;
   logic                   full;
   logic                   empty;

   int n_vec = 0;
   int n_err = 0;
   instr_info_t mq[$];
   instr_info_t o0, o1;

   assign o0 = out_info[INFO_W-1:0];
   assign o1 = out_info[2*INFO_W-1:INFO_W];

   always #5 clk = ~clk;

   instr_info_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .WAYS  (WAYS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_info   (in_info),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_info  (out_info),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, got, exp);
      end
   endtask

   function automatic instr_info_t mk(input logic [31:0] a);
      instr_info_t r;
      r.address             = a;
      r.immediate           = a ^ 32'h0000_0FF0;
      r.instr_name          = a[2] ? ADD : LW;
      r.regs.rd             = a[7:2];
      r.regs.rs1            = a[8:3];
      r.regs.rs2            = a[9:4];
      r.regs.rs3            = 6'h11;
      r.instr_type          = a[2] ? R_TYPE : I_TYPE;
      r.flags.is_branch     = 1'b0;
      r.flags.is_load       = ~a[2];
      r.flags.is_store      = 1'b0;
      r.flags.is_compressed = a[3];
      r.flags.is_illegal    = 1'b0;
      return r;
   endfunction

   function automatic instr_info_t lane_rec(input int w);
      return in_info[w*INFO_W +: INFO_W];
   endfunction

   // Reference model: a plain queue of records, checked every falling edge.
   always @(negedge clk) begin : p_compare
      int          cnt, n_acc, n_take;
      bit          byp, run, ev;
      instr_info_t er;
      if (!rst_n) mq.delete();
      cnt = mq.size();
      byp = 1'b0;
`ifdef INSTR_INFO_QUEUE_BYPASS_EN
      byp = (cnt == 0) && !flush;
`endif
      n_acc = 0;
      if (DEPTH - cnt >= WAYS) begin
         for (int w = 0; w < WAYS; w++) if (in_valid[w]) n_acc++;
      end
      chk("count", 128'(count), 128'(cnt));
      chk("full", 128'(full), 128'(cnt == DEPTH));
      chk("empty", 128'(empty), 128'(cnt == 0));
      chk("in_ready", 128'(in_ready), 128'(DEPTH - cnt >= WAYS));
      n_take = 0;
      run    = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
         ev = byp ? (w < n_acc) : (w < cnt);
         if (!ev)      er = INSTR_INFO_CLEARED;
         else if (byp) er = lane_rec(w);
         else          er = mq[w];
         chk($sformatf("out_valid[%0d]", w), 128'(out_valid[w]), 128'(ev));
         chk($sformatf("out_info[%0d]", w), 128'(out_info[w*INFO_W +: INFO_W]), 128'(er));
         if (run && ev && out_ready[w]) n_take++;
         else run = 1'b0;
      end
      if (rst_n) begin
         if (flush) begin
            mq.delete();
         end else if (byp) begin
            for (int w = n_take; w < n_acc; w++) mq.push_back(lane_rec(w));
         end else begin
            repeat (n_take) void'(mq.pop_front());
            for (int w = 0; w < n_acc; w++) mq.push_back(lane_rec(w));
         end
      end
   end

   // Inputs apply to the next rising edge; on return, outputs reflect all prior edges.
   task automatic drive(input logic f, input logic [1:0] iv, input logic [1:0] ordy,
                        input logic [31:0] a);
      @(posedge clk);
      #1;
      flush     = f;
      in_valid  = iv;
      out_ready = ordy;
      in_info   = {mk(a + 32'd4), mk(a)};
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("reset count", 128'(count), 128'd0);
      chk("reset empty", 128'(empty), 128'd1);
      chk("reset full", 128'(full), 128'd0);
      chk("reset in_ready", 128'(in_ready), 128'd1);
      chk("reset out_valid", 128'(out_valid), 128'd0);
      chk("reset name", 128'(o0.instr_name), 128'(UNKNOWN));

      // Fill to full, then a fifth offer that must be refused.
      drive(0, 2'b11, 2'b00, 32'h100);
      drive(0, 2'b11, 2'b00, 32'h108);
      drive(0, 2'b11, 2'b00, 32'h110);
      drive(0, 2'b11, 2'b00, 32'h118);
      drive(0, 2'b11, 2'b00, 32'h120);
      chk("fill count", 128'(count), 128'd8);
      chk("fill full", 128'(full), 128'd1);
      chk("fill in_ready", 128'(in_ready), 128'd0);
      drive(0, 2'b00, 2'b00, 32'h0);
      chk("fifth count", 128'(count), 128'd8);
      chk("fill head addr", 128'(o0.address), 128'h100);
      chk("fill lane1 addr", 128'(o1.address), 128'h104);
      repeat (4) drive(0, 2'b00, 2'b11, 32'h0);

      // Wrap-around across slot 7 -> 0.
      drive(0, 2'b11, 2'b00, 32'h200);
      drive(0, 2'b11, 2'b00, 32'h208);
      drive(0, 2'b11, 2'b00, 32'h210);
      drive(0, 2'b00, 2'b11, 32'h0);
      drive(0, 2'b00, 2'b11, 32'h0);
      drive(0, 2'b11, 2'b00, 32'h218);
      chk("wrap count2", 128'(count), 128'd2);
      chk("wrap head", 128'(o0.address), 128'h210);
      drive(0, 2'b11, 2'b00, 32'h220);
      drive(0, 2'b00, 2'b11, 32'h0);
      chk("wrap count6", 128'(count), 128'd6);
      drive(0, 2'b00, 2'b11, 32'h0);
      chk("wrap slot6", 128'(o0.address), 128'h218);
      chk("wrap slot7", 128'(o1.address), 128'h21C);
      drive(0, 2'b00, 2'b11, 32'h0);
      chk("wrap slot0", 128'(o0.address), 128'h220);
      chk("wrap slot1", 128'(o1.address), 128'h224);

      // Simultaneous enqueue and dequeue at count 3.
      drive(0, 2'b11, 2'b00, 32'h300);
      drive(0, 2'b01, 2'b00, 32'h308);
      drive(0, 2'b01, 2'b11, 32'h310);
      chk("simul count3", 128'(count), 128'd3);
      chk("simul out0", 128'(o0.address), 128'h300);
      drive(0, 2'b00, 2'b00, 32'h0);
      chk("simul count2", 128'(count), 128'd2);
      chk("simul old", 128'(o0.address), 128'h308);
      chk("simul new", 128'(o1.address), 128'h310);
      drive(0, 2'b00, 2'b11, 32'h0);

      // Flush beats enqueue and dequeue in the same cycle.
      drive(0, 2'b11, 2'b00, 32'h400);
      drive(0, 2'b11, 2'b00, 32'h408);
      drive(0, 2'b01, 2'b00, 32'h410);
      drive(1, 2'b11, 2'b01, 32'h418);
      chk("flush pre count", 128'(count), 128'd5);
      drive(0, 2'b00, 2'b00, 32'h0);
      chk("flush count", 128'(count), 128'd0);
      chk("flush empty", 128'(empty), 128'd1);
      chk("flush out_valid", 128'(out_valid), 128'd0);
      drive(0, 2'b00, 2'b00, 32'h0);
      chk("flush idle valid", 128'(out_valid), 128'd0);

      // Offer two records to an empty queue while taking lane 0 where visible.
`ifdef INSTR_INFO_QUEUE_BYPASS_EN
      drive(0, 2'b11, 2'b01, 32'h500);
      chk("bypass valid", 128'(out_valid), 128'b11);
      chk("bypass addr", 128'(o0.address), 128'h500);
      drive(0, 2'b00, 2'b00, 32'h0);
      chk("bypass count", 128'(count), 128'd1);
      chk("bypass held", 128'(o0.address), 128'h504);
      drive(0, 2'b00, 2'b01, 32'h0);
`else
      drive(0, 2'b11, 2'b00, 32'h500);
      chk("nobypass valid", 128'(out_valid), 128'd0);
      drive(0, 2'b00, 2'b00, 32'h0);
      chk("nobypass count", 128'(count), 128'd2);
      chk("nobypass addr", 128'(o0.address), 128'h500);
      drive(0, 2'b00, 2'b11, 32'h0);
`endif
      drive(0, 2'b00, 2'b00, 32'h0);
      chk("drained empty", 128'(empty), 128'd1);

      // Asynchronous reset in the middle of operation.
      drive(0, 2'b11, 2'b00, 32'h600);
      drive(0, 2'b00, 2'b00, 32'h0);
      chk("pre-reset count", 128'(count), 128'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("async rst count", 128'(count), 128'd0);
      chk("async rst empty", 128'(empty), 128'd1);
      chk("async rst valid", 128'(out_valid), 128'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(0, 2'b00, 2'b00, 32'h0);
      drive(0, 2'b00, 2'b00, 32'h0);
      chk("post-reset count", 128'(count), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_instr_info_queue
`default_nettype wire
